deadtime_scheduler: RTL and testbench

DEADTIME_SCHEDULER -- requirements
Module: deadtime_scheduler

---
 rtl/deadtime_scheduler_pkg.sv | 26 ++
 rtl/deadtime_scheduler_if.sv | 33 +++
 rtl/deadtime_scheduler_seq_divider.sv | 78 +++++++
 rtl/deadtime_scheduler.sv | 170 +++++++++++++++++
 tb/tb_deadtime_scheduler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/deadtime_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : deadtime_pkg
// Purpose: Shared types and constants for the dead-time scheduler.
//          Holds the FSM state encoding, the ADC-to-ns conversion constants
//          (ns = code*NS_PER_LSB + NS_OFFSET), and the optional clamp limits
//          used when DEADTIME_SCHEDULER_CLAMP_EN is defined.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package deadtime_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCALE  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_APPLY  = 2'd3
    } state_t;

    localparam int NS_PER_LSB  = 10;
    localparam int NS_OFFSET   = 100;
    localparam int DT_MIN_CLKS = 12;
    localparam int DT_MAX_CLKS = 625;

endpackage
`default_nettype wire

// File: rtl/deadtime_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : deadtime_scheduler_if
// Purpose: Bundles the sample input, reference PWM and dead-time outputs of
//          the dead-time scheduler.
// Ports  : en, sample_rdy, adc_code, pwm_in   (master -> slave)
//          dt_clks, busy, update_done, overrun (slave -> master)
// Rev    : 1.0  initial release
// ============================================================================
interface deadtime_scheduler_if #(
    parameter int ADC_WIDTH = 9,
    parameter int N         = 12
);
    logic                 en;
    logic                 sample_rdy;
    logic [ADC_WIDTH-1:0] adc_code;
    logic [2:0]           pwm_in;
    logic [3*N-1:0]       dt_clks;
    logic                 busy;
    logic                 update_done;
    logic                 overrun;

    modport master (
        output en, sample_rdy, adc_code, pwm_in,
        input  dt_clks, busy, update_done, overrun
    );

    modport slave (
        input  en, sample_rdy, adc_code, pwm_in,
        output dt_clks, busy, update_done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/deadtime_scheduler_seq_divider.sv
`default_nettype none
// ============================================================================
// Module : seq_divider
// Purpose: Restoring divider, one quotient bit per clock, NUM_W iterations.
//          start_i loads the operands; done_o is high during the final
//          iteration cycle and quot_o then carries the complete quotient
//          (floor(num/den)), so the caller can capture it on that edge.
// Ports  : clk, rst            clock / synchronous active-high reset
//          start_i             load num_i / den_i and begin
//          num_i [NUM_W]       dividend
//          den_i [DEN_W]       divisor (non-zero)
//          done_o              last iteration in progress
//          quot_o [NUM_W]      quotient, valid while done_o is high
// Rev    : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int NUM_W = 14,
    parameter int DEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             done_o,
    output logic [NUM_W-1:0] quot_o
);
    localparam int CW = $clog2(NUM_W + 1);

    logic             active_q;
    logic [CW-1:0]    cnt_q;
    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [NUM_W-1:0] dvd_q;

    logic [DEN_W:0]   w_trial;
    logic [DEN_W:0]   w_diff;
    logic             w_ge;
    logic [DEN_W-1:0] w_rem_d;
    logic [NUM_W-1:0] w_dvd_d;

    always_comb begin
        w_trial = {rem_q, dvd_q[NUM_W-1]};
        w_diff  = w_trial - {1'b0, den_q};
        w_ge    = (w_trial >= {1'b0, den_q});
        // The partial remainder is always below den, so DEN_W bits suffice.
        w_rem_d = DEN_W'(w_ge ? w_diff : w_trial);
        w_dvd_d = {dvd_q[NUM_W-2:0], w_ge};
    end

    assign done_o = active_q && (cnt_q == CW'(NUM_W - 1));
    assign quot_o = w_dvd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            den_q    <= '0;
            dvd_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            rem_q    <= '0;
            den_q    <= den_i;
            dvd_q    <= num_i;
        end else if (active_q) begin
            rem_q <= w_rem_d;
            dvd_q <= w_dvd_d;
            cnt_q <= cnt_q + CW'(1);
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/deadtime_scheduler.sv
`default_nettype none
// ============================================================================
// Module : deadtime_scheduler
// Purpose: Converts an averaged ADC code to a dead time in clocks,
//          dt = floor((code*10 + 100) / CLK_PERIOD), saturated to N bits,
//          and applies it to three channels, each on the falling edge of its
//          reference PWM (or all at once on APPLY timeout). Samples arriving
//          while busy are kept in a one-deep holding register.
//          Optional build macro DEADTIME_SCHEDULER_CLAMP_EN clamps the result
//          to [DT_MIN_CLKS, DT_MAX_CLKS].
// Ports  : clk, rst         clock / synchronous active-high reset
//          bus (slave)      en, sample_rdy, adc_code, pwm_in[2:0] in;
//                           dt_clks[3*N], busy, update_done, overrun out
// Rev    : 1.0  initial release
// ============================================================================
module deadtime_scheduler
    import deadtime_pkg::*;
#(
    parameter int CLK_PERIOD    = 8,
    parameter int ADC_WIDTH     = 9,
    parameter int N             = 12,
    parameter int NUM_W         = 14,
    parameter int DT_RESET_CLKS = 13,
    parameter int TIMEOUT_CLKS  = 131071
) (
    input  logic                 clk,
    input  logic                 rst,
    deadtime_scheduler_if.slave  bus
);
    localparam int               TW    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [NUM_W-1:0] C_NS  = NUM_W'(NS_PER_LSB);
    localparam logic [NUM_W-1:0] C_OFS = NUM_W'(NS_OFFSET);

    state_t                 state_q;
    logic [ADC_WIDTH-1:0]   code_q;
    logic [ADC_WIDTH-1:0]   hold_q;
    logic                   hold_v_q;
    logic [2:0][N-1:0]      dt_q;
    logic [N-1:0]           new_q;
    logic [2:0]             pending_q;
    logic [2:0]             pwm_prev_q;
    logic [TW-1:0]          tmo_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   overrun_q;

    logic [NUM_W-1:0]       w_num;
    logic                   w_div_done;
    logic [NUM_W-1:0]       w_quot;
    logic [NUM_W+N-1:0]     w_quot_ext;
    logic [N-1:0]           w_sat;
    logic [N-1:0]           w_result;
    logic [2:0]             w_fall;
    logic                   w_tmo;
    logic [2:0]             w_load;
    logic [2:0]             w_pend_d;

    assign w_num = NUM_W'(code_q) * C_NS + C_OFS;

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (8)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (state_q == ST_SCALE),
        .num_i   (w_num),
        .den_i   (8'(CLK_PERIOD)),
        .done_o  (w_div_done),
        .quot_o  (w_quot)
    );

    // Zero-extend so the overflow test works for any NUM_W/N combination.
    assign w_quot_ext = {{N{1'b0}}, w_quot};
    assign w_sat      = (w_quot_ext[NUM_W+N-1:N] != '0) ? '1 : w_quot_ext[N-1:0];

`ifdef DEADTIME_SCHEDULER_CLAMP_EN
    localparam logic [N-1:0] C_MIN = N'(DT_MIN_CLKS);
    localparam logic [N-1:0] C_MAX = N'(DT_MAX_CLKS);
    assign w_result = (w_sat < C_MIN) ? C_MIN :
                      (w_sat > C_MAX) ? C_MAX : w_sat;
`else
    assign w_result = w_sat;
`endif

    // A channel loads on its own falling edge, or together with every other
    // still-pending channel once the APPLY wait has run out.
    assign w_fall   = pwm_prev_q & ~bus.pwm_in;
    assign w_tmo    = (tmo_q == TW'(TIMEOUT_CLKS - 1));
    assign w_load   = pending_q & (w_fall | {3{w_tmo}});
    assign w_pend_d = pending_q & ~w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            code_q     <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            dt_q       <= {3{N'(DT_RESET_CLKS)}};
            new_q      <= '0;
            pending_q  <= '0;
            pwm_prev_q <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pwm_prev_q <= bus.pwm_in;
            done_q     <= 1'b0;

            if (state_q != ST_IDLE && bus.sample_rdy) begin
                hold_q    <= bus.adc_code;
                hold_v_q  <= 1'b1;
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // A fresh accepted sample supersedes any held one.
                    if (bus.sample_rdy && bus.en) begin
                        code_q   <= bus.adc_code;
                        hold_v_q <= 1'b0;
                        state_q  <= ST_SCALE;
                        busy_q   <= 1'b1;
                    end else if (hold_v_q) begin
                        code_q   <= hold_q;
                        hold_v_q <= 1'b0;
                        state_q  <= ST_SCALE;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SCALE: begin
                    state_q <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    if (w_div_done) begin
                        new_q     <= w_result;
                        pending_q <= 3'b111;
                        tmo_q     <= '0;
                        state_q   <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    for (int i = 0; i < 3; i++) begin
                        if (w_load[i]) begin
                            dt_q[i] <= new_q;
                        end
                    end
                    pending_q <= w_pend_d;
                    tmo_q     <= tmo_q + TW'(1);
                    if (w_pend_d == 3'b000) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dt_clks     = dt_q;
    assign bus.busy        = busy_q;
    assign bus.update_done = done_q;
    assign bus.overrun     = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_deadtime_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_deadtime_scheduler
// Purpose: Self-checking bench for deadtime_scheduler. Expected dead times
//          come from an arithmetic model of the conversion rule; expected
//          load cycles come from the per-channel edge offsets and the APPLY
//          timeout. Honours DEADTIME_SCHEDULER_CLAMP_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_deadtime_scheduler;
    localparam int NUM_W   = 14;
    localparam int N       = 12;
    localparam int CLK_PER = 8;
    localparam int TMO     = 64;
    localparam int RST_VAL = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    deadtime_scheduler_if #(.ADC_WIDTH(9), .N(N)) bus ();

    deadtime_scheduler #(
        .CLK_PERIOD    (CLK_PER),
        .ADC_WIDTH     (9),
        .N             (N),
        .NUM_W         (NUM_W),
        .DT_RESET_CLKS (RST_VAL),
        .TIMEOUT_CLKS  (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_dt [3];
    bit exp_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_dt(input int code);
        int num;
        int q;
        num = (code * 10 + 100) % (1 << NUM_W);
        q   = num / CLK_PER;
        if (q > (1 << N) - 1) q = (1 << N) - 1;
`ifdef DEADTIME_SCHEDULER_CLAMP_EN
        if (q < 12)  q = 12;
        if (q > 625) q = 625;
`endif
        return q;
    endfunction

    task automatic check_outs(input string tag, input int eb, input int ed);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s dt[%0d]", tag, i), 32'(bus.dt_clks[i*N +: N]), 32'(exp_dt[i]));
        end
        chk({tag, " busy"},    32'(bus.busy),        32'(eb));
        chk({tag, " done"},    32'(bus.update_done), 32'(ed));
        chk({tag, " overrun"}, 32'(bus.overrun),     32'(exp_ovr));
    endtask

    // One conversion: offsets are the APPLY cycle on which each channel's
    // PWM falls; values past the timeout mean the channel never falls.
    task automatic run_sample(input int code, input bit from_hold, input bit inject,
                              input int o0, input int o1, input int o2, input int want);
        int off [3];
        int ld  [3];
        int last;
        int nv;
        off = '{o0, o1, o2};
        nv  = (want < 0) ? ref_dt(code) : want;
        if (!from_hold) begin
            @(negedge clk);
            bus.adc_code   = 9'(code);
            bus.sample_rdy = 1'b1;
        end
        @(posedge clk); #1 bus.sample_rdy = 1'b0;
        for (int w = 0; w < NUM_W + 1; w++) begin
            if (inject && w >= 2 && w <= 4) begin
                bus.adc_code   = 9'(10 * (w - 1));
                bus.sample_rdy = 1'b1;
                exp_ovr        = 1'b1;
            end
            @(posedge clk); #1 bus.sample_rdy = 1'b0;
        end
        check_outs($sformatf("apply entry code=%0d", code), 1, 0);
        last = 0;
        for (int i = 0; i < 3; i++) begin
            ld[i] = (off[i] < TMO - 1) ? off[i] : TMO - 1;
            if (ld[i] > last) last = ld[i];
        end
        for (int k = 0; k <= last; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (k >= off[i]) bus.pwm_in[i] = 1'b0;
            end
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (k == ld[i]) exp_dt[i] = nv;
            end
            check_outs($sformatf("code=%0d k=%0d", code, k), (k < last) ? 1 : 0, (k == last) ? 1 : 0);
        end
        bus.pwm_in = 3'b111;
    endtask

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.sample_rdy = 1'b0;
        bus.adc_code   = '0;
        bus.pwm_in     = 3'b111;
        exp_ovr        = 1'b0;
        for (int i = 0; i < 3; i++) exp_dt[i] = RST_VAL;
        repeat (3) @(posedge clk);
        #1 check_outs("reset", 0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Staggered falling edges, nominal code.
        run_sample(100, 0, 0, 0, 5, 10, 137);
        // Simultaneous edges; minimum and maximum codes.
        run_sample(0, 0, 0, 2, 2, 2, 12);
`ifdef DEADTIME_SCHEDULER_CLAMP_EN
        run_sample(511, 0, 0, 1, 4, 0, 625);
`else
        run_sample(511, 0, 0, 1, 4, 0, 651);
`endif
        // No edges at all: everything loads on the timeout cycle.
        run_sample(50, 0, 0, 100, 100, 100, -1);
        // Mixed: one channel relies on the timeout.
        run_sample(77, 0, 0, 3, 100, 20, -1);

        // Samples 10, 20, 30 while busy; only 30 survives.
        run_sample(300, 0, 1, 1, 2, 3, -1);
        run_sample(30, 1, 0, 0, 1, 2, 50);

        // Reset while dividing.
        @(negedge clk);
        bus.adc_code   = 9'd200;
        bus.sample_rdy = 1'b1;
        @(posedge clk); #1 bus.sample_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_dt[i] = RST_VAL;
        exp_ovr = 1'b0;
        check_outs("rst mid divide", 0, 0);
        for (int c = 0; c < NUM_W + 4; c++) begin
            @(posedge clk); #1;
            chk("post-rst done", 32'(bus.update_done), 32'd0);
        end
        check_outs("post-rst idle", 0, 0);

        // Disabled: sample strobes ignored.
        bus.en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            bus.adc_code   = 9'(100 + p);
            bus.sample_rdy = 1'b1;
            @(posedge clk); #1 bus.sample_rdy = 1'b0;
            @(posedge clk); #1;
            check_outs($sformatf("en=0 pulse %0d", p), 0, 0);
        end
        repeat (NUM_W + 4) @(posedge clk);
        #1 check_outs("en=0 settle", 0, 0);
        bus.en = 1'b1;

        // Randomized conversions with random edge placement.
        for (int r = 0; r < 8; r++) begin
            run_sample(int'($urandom_range(0, 511)), 0, 0,
                       int'($urandom_range(0, 70)), int'($urandom_range(0, 70)),
                       int'($urandom_range(0, 70)), -1);
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
